// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: default sizing and Gray/binary pointer conversion.
// Both the write-side and read-side pointer blocks use these helpers.
package fifo_pkg;

   localparam int DEF_ADDR_WIDTH = 6;
   localparam int MAX_W          = 32;

   function automatic int depth(input int aw);
      return 1 << aw;
   endfunction

   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Prefix-XOR from the MSB down. This works for any width as long as the
   // caller zero-extends the input.
   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
      logic [MAX_W-1:0] b;
      b = g;
      for (int s = 1; s < MAX_W; s = s * 2)
         b = b ^ (b >> s);
      return b;
   endfunction

endpackage

// File: rtl/wptr_full_if.sv
// Write-side bundle between the write client, the RAM write port and the pointer synchronizers.
interface wptr_full_if #(
   parameter int ADDR_WIDTH = fifo_pkg::DEF_ADDR_WIDTH
);
   logic                  winc;
   logic                  clr_overflow;
   logic [ADDR_WIDTH:0]   rptr_sync;
   logic                  wen;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [ADDR_WIDTH:0]   wptr;
   logic                  wfull;
   logic                  walmost_full;
   logic [ADDR_WIDTH:0]   wlevel;
   logic                  overflow;

   modport master (
      output winc, clr_overflow, rptr_sync,
      input  wen, waddr, wptr, wfull, walmost_full, wlevel, overflow
   );

   modport slave (
      input  winc, clr_overflow, rptr_sync,
      output wen, waddr, wptr, wfull, walmost_full, wlevel, overflow
   );
endinterface

// File: rtl/wptr_full.sv
// Write-domain pointer/status block: binary write address, registered Gray wptr,
// and full / almost-full / level / sticky overflow derived from the synchronized read pointer.
module wptr_full
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int AF_MARGIN  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   wptr_full_if.slave  bus
);
   localparam int PW    = ADDR_WIDTH + 1;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

   logic [PW-1:0] wbin, wbin_next, wgray_next, rbin, lvl_next;
   logic [PW-1:0] wptr_q, wlevel_q;
   logic          wfull_q, waf_q, ovf_q;
   logic          wen;
   logic          full_next;

   assign wen        = bus.winc & ~wfull_q;
   assign wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, wen};
   assign wgray_next = PW'(bin2gray(MAX_W'(wbin_next)));
   assign rbin       = PW'(gray2bin(MAX_W'(bus.rptr_sync)));
   assign lvl_next   = wbin_next - rbin;

   // The write pointer has wrapped once more than the read pointer: the top two Gray bits differ and the rest match.
   assign full_next  = (wgray_next == {~bus.rptr_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                                       bus.rptr_sync[ADDR_WIDTH-2:0]});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin     <= '0;
         wptr_q   <= '0;
         wfull_q  <= 1'b0;
         waf_q    <= 1'b0;
         wlevel_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wbin     <= wbin_next;
         wptr_q   <= wgray_next;
         wfull_q  <= full_next;
         waf_q    <= (lvl_next >= AF_THRESH);
         wlevel_q <= lvl_next;
         // When a set and a clear arrive in the same cycle, the set wins.
         if (bus.winc && wfull_q)
            ovf_q <= 1'b1;
         else if (bus.clr_overflow)
            ovf_q <= 1'b0;
      end
   end

   assign bus.wen          = wen;
   assign bus.waddr        = wbin[ADDR_WIDTH-1:0];
   assign bus.wptr         = wptr_q;
   assign bus.wfull        = wfull_q;
   assign bus.walmost_full = waf_q;
   assign bus.wlevel       = wlevel_q;
   assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full: depth-8 instance (AF_MARGIN=2) plus a depth-64 instance for the long fill.
module tb_wptr_full;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   wptr_full_if #(.ADDR_WIDTH(3)) b3 ();
   wptr_full_if #(.ADDR_WIDTH(6)) b6 ();

   wptr_full #(.ADDR_WIDTH(3), .AF_MARGIN(2)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
   wptr_full #(.ADDR_WIDTH(6), .AF_MARGIN(4)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      b3.winc = 1'b1; b3.clr_overflow = 1'b0; b3.rptr_sync = 4'b0000;
      rst_n = 1'b1;
      tick(); tick(); tick();
      #2 rst_n = 1'b0;   // asserted between edges
      #1;
      n_cmp++;
      if ({b3.wptr, b3.wlevel, b3.waddr, b3.wfull, b3.walmost_full, b3.overflow} !== 14'd0) begin
         n_err++;
         $display("FAIL reset_async got wptr=%b lvl=%0d waddr=%0d full=%b af=%b ovf=%b want all 0",
                  b3.wptr, b3.wlevel, b3.waddr, b3.wfull, b3.walmost_full, b3.overflow);
      end
      n_cmp++;
      if (b3.wen !== 1'b1) begin n_err++; $display("FAIL reset_wen got %b want 1", b3.wen); end
      b3.winc = 1'b0;
      tick();
      rst_n = 1'b1;
      tick(); tick();
      n_cmp++;
      if ({b3.wptr, b3.wlevel, b3.waddr, b3.wfull, b3.walmost_full, b3.overflow, b3.wen} !== 15'd0) begin
         n_err++;
         $display("FAIL reset_idle got wptr=%b lvl=%0d waddr=%0d wen=%b want all 0",
                  b3.wptr, b3.wlevel, b3.waddr, b3.wen);
      end
   endtask

   task automatic test_fill();
      b3.rptr_sync = 4'b0000;
      b3.winc = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (b3.waddr !== 3'(i)) begin
            n_err++; $display("FAIL fill_waddr[%0d] got %0d want %0d", i, b3.waddr, i);
         end
         tick();
         if (i == 4) begin
            n_cmp++;
            if (b3.walmost_full !== 1'b0 || b3.wlevel !== 4'd5) begin
               n_err++; $display("FAIL fill_af5 got af=%b lvl=%0d want af=0 lvl=5", b3.walmost_full, b3.wlevel);
            end
         end
         if (i == 5) begin
            n_cmp++;
            if (b3.walmost_full !== 1'b1 || b3.wlevel !== 4'd6) begin
               n_err++; $display("FAIL fill_af6 got af=%b lvl=%0d want af=1 lvl=6", b3.walmost_full, b3.wlevel);
            end
         end
         if (i == 6) begin
            n_cmp++;
            if (b3.wfull !== 1'b0) begin n_err++; $display("FAIL fill_notfull7 got %b want 0", b3.wfull); end
         end
      end
      n_cmp++;
      if (b3.wfull !== 1'b1 || b3.wlevel !== 4'd8 || b3.wptr !== 4'b1100 || b3.waddr !== 3'd0) begin
         n_err++;
         $display("FAIL fill_full got full=%b lvl=%0d wptr=%b waddr=%0d want 1 8 1100 0",
                  b3.wfull, b3.wlevel, b3.wptr, b3.waddr);
      end
   endtask

   task automatic test_overflow();
      b3.winc = 1'b1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (b3.wen !== 1'b0) begin n_err++; $display("FAIL ovf_wen[%0d] got %b want 0", i, b3.wen); end
         tick();
         n_cmp++;
         if (b3.wptr !== 4'b1100 || b3.overflow !== 1'b1 || b3.wlevel !== 4'd8) begin
            n_err++;
            $display("FAIL ovf_hold[%0d] got wptr=%b ovf=%b lvl=%0d want 1100 1 8", i, b3.wptr, b3.overflow, b3.wlevel);
         end
      end
      b3.winc = 1'b0; b3.clr_overflow = 1'b1;
      tick();
      n_cmp++;
      if (b3.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", b3.overflow); end
      b3.winc = 1'b1;
      tick();
      n_cmp++;
      if (b3.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins got %b want 1", b3.overflow); end
      b3.winc = 1'b0; b3.clr_overflow = 1'b0;
   endtask

   task automatic test_drain_release();
      b3.rptr_sync = 4'b0001;
      n_cmp++;
      if (b3.wfull !== 1'b1) begin n_err++; $display("FAIL drain_still_full got %b want 1", b3.wfull); end
      tick();
      n_cmp++;
      if (b3.wfull !== 1'b0 || b3.wlevel !== 4'd7) begin
         n_err++; $display("FAIL drain_release got full=%b lvl=%0d want 0 7", b3.wfull, b3.wlevel);
      end
      b3.winc = 1'b1;
      tick();
      b3.winc = 1'b0;
      n_cmp++;
      if (b3.wfull !== 1'b1 || b3.wptr !== 4'b1101 || b3.wlevel !== 4'd8) begin
         n_err++; $display("FAIL drain_refill got full=%b wptr=%b lvl=%0d want 1 1101 8", b3.wfull, b3.wptr, b3.wlevel);
      end
   endtask

   task automatic test_wrap();
      b3.winc = 1'b0; b3.rptr_sync = 4'b0000;
      do_reset();
      b3.winc = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      b3.winc = 1'b0;
      b3.rptr_sync = 4'b1100;   // reader caught up at binary 8
      tick();
      n_cmp++;
      if (b3.wlevel !== 4'd0 || b3.wfull !== 1'b0) begin
         n_err++; $display("FAIL wrap_empty got lvl=%0d full=%b want 0 0", b3.wlevel, b3.wfull);
      end
      b3.winc = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (b3.waddr !== 3'(i)) begin
            n_err++; $display("FAIL wrap_waddr[%0d] got %0d want %0d", i, b3.waddr, i);
         end
         tick();
      end
      b3.winc = 1'b0;
      n_cmp++;
      if (b3.wptr !== 4'b0000 || b3.wfull !== 1'b1 || b3.wlevel !== 4'd8 || b3.waddr !== 3'd0) begin
         n_err++;
         $display("FAIL wrap_full got wptr=%b full=%b lvl=%0d waddr=%0d want 0000 1 8 0",
                  b3.wptr, b3.wfull, b3.wlevel, b3.waddr);
      end
   endtask

   task automatic test_simultaneous();
      b3.winc = 1'b0; b3.rptr_sync = 4'b0000;
      do_reset();
      b3.winc = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      n_cmp++;
      if (b3.wlevel !== 4'd4) begin n_err++; $display("FAIL simul_pre got %0d want 4", b3.wlevel); end
      b3.rptr_sync = 4'b0001;
      tick();
      b3.winc = 1'b0;
      n_cmp++;
      if (b3.wlevel !== 4'd4 || b3.walmost_full !== 1'b0 || b3.wptr !== 4'b0111) begin
         n_err++;
         $display("FAIL simul_lvl got lvl=%0d af=%b wptr=%b want 4 0 0111", b3.wlevel, b3.walmost_full, b3.wptr);
      end
   endtask

   task automatic test_deep_fill();
      b6.winc = 1'b0; b6.clr_overflow = 1'b0; b6.rptr_sync = 7'd0;
      do_reset();
      b6.winc = 1'b1;
      for (int i = 0; i < 63; i++) tick();
      n_cmp++;
      if (b6.wfull !== 1'b0 || b6.wlevel !== 7'd63) begin
         n_err++; $display("FAIL deep_63 got full=%b lvl=%0d want 0 63", b6.wfull, b6.wlevel);
      end
      tick();
      b6.winc = 1'b0;
      n_cmp++;
      if (b6.wfull !== 1'b1 || b6.wlevel !== 7'd64 || b6.wptr !== 7'b1100000) begin
         n_err++; $display("FAIL deep_64 got full=%b lvl=%0d wptr=%b want 1 64 1100000", b6.wfull, b6.wlevel, b6.wptr);
      end
   endtask

   initial begin
      b3.winc = 1'b0; b3.clr_overflow = 1'b0; b3.rptr_sync = '0;
      b6.winc = 1'b0; b6.clr_overflow = 1'b0; b6.rptr_sync = '0;
      tick();
      test_reset();
      test_fill();
      test_overflow();
      test_drain_release();
      test_wrap();
      test_simultaneous();
      test_deep_fill();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
